// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the RV32I core.
// Drives a variable-latency req/ready instruction memory and keeps a one-entry skid buffer.
module fetch_stage #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR     = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FULL} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] FOUR = ADDRESS_WIDTH'(4);

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] pcf, pcf_nxt;
  logic [ADDRESS_WIDTH-1:0] redir_pc, redir_nxt;
  logic [DATA_WIDTH-1:0]    skid_instr;
  logic [ADDRESS_WIDTH-1:0] skid_pc;
  logic                     skid_ld;
  logic                     deliver;
  logic [DATA_WIDTH-1:0]    del_instr;
  logic [ADDRESS_WIDTH-1:0] del_pc;

  // The request address is PCF in every requesting state; DRAIN keeps the
  // killed request's address until imem completes it.
  assign imem_addr = pcf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pcf      <= RESET_PC;
      redir_pc <= '0;
    end else begin
      state    <= state_nxt;
      pcf      <= pcf_nxt;
      redir_pc <= redir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pcf_nxt   = pcf;
    redir_nxt = redir_pc;
    skid_ld   = 1'b0;
    deliver   = 1'b0;
    del_instr = imem_rdata;
    del_pc    = pcf;
    imem_req  = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (PCSrcE) begin
          if (imem_ready) begin
            pcf_nxt = PCTargetE;
          end else begin
            redir_nxt = PCTargetE;
            state_nxt = DRAIN;
          end
        end else if (imem_ready) begin
          pcf_nxt = pcf + FOUR;
          if (StallD) begin
            skid_ld   = 1'b1;
            state_nxt = FULL;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        // Newest redirect wins, including one arriving with the response.
        if (PCSrcE) redir_nxt = PCTargetE;
        if (imem_ready) begin
          pcf_nxt   = PCSrcE ? PCTargetE : redir_pc;
          state_nxt = FETCH;
        end
      end
      FULL: begin
        if (PCSrcE) begin
          pcf_nxt   = PCTargetE;
          state_nxt = FETCH;
        end else if (!StallD) begin
          deliver   = 1'b1;
          del_instr = skid_instr;
          del_pc    = skid_pc;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (skid_ld) begin
      skid_instr <= imem_rdata;
      skid_pc    <= pcf;
    end
  end

  // IF/ID: flush beats stall beats load; an unstalled cycle with nothing to
  // deliver inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD || (!StallD && !deliver)) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= del_instr;
      PCD      <= del_pc;
      PCPlus4D <= del_pc + FOUR;
      ValidD   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int vectors = 0;
  int miscompares = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  // Model: fetch is a stream of requests; a request may be "killed" by a
  // redirect and then completes without delivering; a parked instruction
  // waits in a one-slot queue while decode is stalled.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4; logic valid; } ifid_t;

  bit          m_warmup;
  logic [31:0] m_pcf;
  bit          m_killed;
  logic [31:0] m_redirect;
  entry_t      m_parked[$];
  ifid_t       m_ifid;

  function automatic ifid_t bubble();
    ifid_t b;
    b.instr = 32'h13; b.pc = 0; b.pc4 = 0; b.valid = 0;
    return b;
  endfunction

  task automatic model_reset();
    m_warmup = 1; m_pcf = 0; m_killed = 0; m_redirect = 0;
    m_parked.delete();
    m_ifid = bubble();
  endtask

  task automatic model_step();
    bit     got = 0;
    entry_t e;
    e.instr = 0; e.pc = 0;
    if (m_warmup) begin
      m_warmup = 0;
    end else if (m_parked.size() != 0) begin
      if (PCSrcE) begin
        m_parked.delete();
        m_pcf = PCTargetE;
      end else if (!StallD) begin
        e = m_parked.pop_front();
        got = 1;
      end
    end else if (m_killed) begin
      if (PCSrcE) m_redirect = PCTargetE;
      if (imem_ready) begin
        m_pcf = m_redirect;
        m_killed = 0;
      end
    end else if (PCSrcE) begin
      if (imem_ready) m_pcf = PCTargetE;
      else begin m_killed = 1; m_redirect = PCTargetE; end
    end else if (imem_ready) begin
      e.instr = mem(m_pcf); e.pc = m_pcf;
      if (StallD) m_parked.push_back(e);
      else got = 1;
      m_pcf = m_pcf + 4;
    end
    if (FlushD) m_ifid = bubble();
    else if (!StallD) begin
      if (got) begin
        m_ifid.instr = e.instr; m_ifid.pc = e.pc; m_ifid.pc4 = e.pc + 4; m_ifid.valid = 1;
      end else m_ifid = bubble();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic exp_req;
    exp_req = !m_warmup && (m_parked.size() == 0);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pcf);
    chk("InstrD", InstrD, m_ifid.instr);
    chk("PCD", PCD, m_ifid.pc);
    chk("PCPlus4D", PCPlus4D, m_ifid.pc4);
    chk("ValidD", {31'b0, ValidD}, {31'b0, m_ifid.valid});
  endtask

  // Called at a negedge: drive inputs, advance one clock, check at next negedge.
  task automatic step(input logic s, input logic f, input logic p,
                      input logic [31:0] t, input logic r);
    StallD = s; FlushD = f; PCSrcE = p; PCTargetE = t; imem_ready = r;
    imem_rdata = mem(imem_addr);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0; imem_ready = 0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    compare();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("reset InstrD", InstrD, 32'h13);
    chk("reset ValidD", {31'b0, ValidD}, 32'd0);
    chk("reset imem_req", {31'b0, imem_req}, 32'd0);

    // Back-to-back fetch with ready every cycle; ready during IDLE is ignored.
    step(0, 0, 0, 0, 1);
    chk("t1 addr0", imem_addr, 32'h0);
    step(0, 0, 0, 0, 1);
    chk("t1 PCD0", PCD, 32'h0);
    chk("t1 PC4", PCPlus4D, 32'h4);
    chk("t1 valid", {31'b0, ValidD}, 32'd1);
    chk("t1 addr4", imem_addr, 32'h4);
    step(0, 0, 0, 0, 1);
    chk("t1 PCD4", PCD, 32'h4);

    // Three-cycle memory wait: address holds, bubbles flow.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("t2 addr held", imem_addr, 32'h8);
      chk("t2 bubble", InstrD, 32'h13);
    end
    step(0, 0, 0, 0, 1);
    chk("t2 PCD8", PCD, 32'h8);

    // Stall while a response arrives: skid holds PC 0xC, no request in FULL.
    step(1, 0, 0, 0, 1);
    chk("t3 req off", {31'b0, imem_req}, 32'd0);
    chk("t3 hold", PCD, 32'h8);
    step(1, 0, 0, 0, 1);
    chk("t3 req off2", {31'b0, imem_req}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("t3 skid out", PCD, 32'hC);
    chk("t3 resume", imem_addr, 32'h10);
    step(0, 0, 0, 0, 1);
    chk("t3 next", PCD, 32'h10);

    // Redirect with request pending.
    step(0, 0, 1, 32'h100, 0);
    chk("t4 addr held", imem_addr, 32'h14);
    step(0, 0, 0, 0, 1);
    chk("t4 redirected", imem_addr, 32'h100);
    chk("t4 no old", {31'b0, ValidD}, 32'd0);
    step(0, 0, 0, 0, 1);
    chk("t4 PCD", PCD, 32'h100);

    // Flush beats stall; then reset asynchronously while draining.
    step(1, 1, 0, 0, 0);
    chk("t5 flush", {31'b0, ValidD}, 32'd0);
    chk("t5 flushNOP", InstrD, 32'h13);
    step(0, 0, 1, 32'h200, 0);
    step(0, 0, 0, 0, 0);
    do_reset();
    chk("t5 reset req", {31'b0, imem_req}, 32'd0);
    chk("t5 reset PCD", PCD, 32'h0);

    // Redirect to the top of the address space and wrap.
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("t6 addr top", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    chk("t6 PCD top", PCD, 32'hFFFF_FFFC);
    chk("t6 PC4 wrap", PCPlus4D, 32'h0);
    chk("t6 addr wrap", imem_addr, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
             $urandom_range(0, 99) < 10,
             ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC),
             $urandom_range(0, 99) < 65);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
